// File: rtl/sprite_loc_ctrl_if.sv
// -----------------------------------------------------------------------------
// sprite_loc_ctrl_if
// Bundles every signal between a maze sprite location controller and its
// environment: direction input, movement tick, map RAM read port, move
// handshake toward the RAM writer, and position/status outputs.
//   master : the location controller (drives map reads, move_req, status)
//   slave  : the environment (drives dir_in, step, map_rd_data, move_ack)
// Parameters X_W / Y_W / CNT_W must match the controller instance.
// -----------------------------------------------------------------------------
interface sprite_loc_ctrl_if #(
    parameter int X_W   = 6,
    parameter int Y_W   = 5,
    parameter int CNT_W = 16
);
    logic [3:0]       dir_in;
    logic             step;
    logic             map_rd_en;
    logic [X_W-1:0]   map_rd_x;
    logic [Y_W-1:0]   map_rd_y;
    logic [1:0]       map_rd_data;
    logic             move_req;
    logic             move_ack;
    logic [X_W-1:0]   curr_x;
    logic [Y_W-1:0]   curr_y;
    logic [X_W-1:0]   next_x;
    logic [Y_W-1:0]   next_y;
    logic [3:0]       heading;
    logic [CNT_W-1:0] pill_count;
    logic             power_eat;
    logic             busy;

    modport master (
        input  dir_in, step, map_rd_data, move_ack,
        output map_rd_en, map_rd_x, map_rd_y, move_req,
               curr_x, curr_y, next_x, next_y,
               heading, pill_count, power_eat, busy
    );

    modport slave (
        output dir_in, step, map_rd_data, move_ack,
        input  map_rd_en, map_rd_x, map_rd_y, move_req,
               curr_x, curr_y, next_x, next_y,
               heading, pill_count, power_eat, busy
    );
endinterface

// File: rtl/sprite_loc_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_loc_ctrl
// Grid-position controller for a maze sprite (Pac-Man or ghost). Holds the
// current tile, buffers the latest one-hot direction as a pending turn, and on
// each step tick probes the map RAM: pending turn first, then current heading.
// Edges wrap (WRAP=1) or block (WRAP=0). An accepted move is handed to the RAM
// writer with move_req/move_ack; pills and power pills eaten are counted.
// Ports:
//   CLOCK_50 : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : sprite_loc_ctrl_if.master (dir_in, step, map read port,
//              move_req/move_ack, curr/next position, heading, pill_count,
//              power_eat, busy)
// Direction encoding {up,down,left,right}: 1000 up, 0100 down, 0010 left,
// 0001 right, 0000 stopped.
// -----------------------------------------------------------------------------
module sprite_loc_ctrl #(
    parameter int X_W     = 6,
    parameter int Y_W     = 5,
    parameter int MAP_W   = 40,
    parameter int MAP_H   = 30,
    parameter int START_X = 20,
    parameter int START_Y = 20,
    parameter int RD_LAT  = 1,
    parameter int WRAP    = 1,
    parameter int CNT_W   = 16
) (
    input logic               CLOCK_50,
    input logic               reset_n,
    sprite_loc_ctrl_if.master bus
);

    localparam logic [3:0]       DIR_UP    = 4'b1000;
    localparam logic [3:0]       DIR_DOWN  = 4'b0100;
    localparam logic [3:0]       DIR_LEFT  = 4'b0010;
    localparam logic [3:0]       DIR_RIGHT = 4'b0001;
    localparam logic [3:0]       DIR_NONE  = 4'b0000;
    localparam logic [X_W-1:0]   X_ZERO    = {X_W{1'b0}};
    localparam logic [Y_W-1:0]   Y_ZERO    = {Y_W{1'b0}};
    localparam logic [X_W-1:0]   X_ONE     = X_W'(1);
    localparam logic [Y_W-1:0]   Y_ONE     = Y_W'(1);
    localparam logic [X_W-1:0]   X_LAST    = X_W'(MAP_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(MAP_H - 1);
    localparam logic [X_W-1:0]   X_START   = X_W'(START_X);
    localparam logic [Y_W-1:0]   Y_START   = Y_W'(START_Y);
    localparam logic [1:0]       LAT_LAST  = 2'(RD_LAT - 1);
    localparam logic [1:0]       TILE_WALL = 2'd1;
    localparam logic [1:0]       TILE_PWR  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRY_P,
        S_WAIT_P,
        S_TRY_H,
        S_WAIT_H,
        S_MOVE
    } state_t;

    typedef struct packed {
        logic           blk;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } tgt_t;

    // Neighbouring tile in direction d. Arithmetic stays inside the map
    // (modulo MAP_W / MAP_H), so non-power-of-two maps wrap correctly.
    // Anything but a one-hot direction yields a blocked target.
    function automatic tgt_t calc_tgt(input logic [X_W-1:0] x,
                                      input logic [Y_W-1:0] y,
                                      input logic [3:0]     d);
        tgt_t t;
        t.blk = 1'b0;
        t.x   = x;
        t.y   = y;
        case (d)
            DIR_UP: begin
                if (y != Y_ZERO)    t.y   = y - Y_ONE;
                else if (WRAP != 0) t.y   = Y_LAST;
                else                t.blk = 1'b1;
            end
            DIR_DOWN: begin
                if (y != Y_LAST)    t.y   = y + Y_ONE;
                else if (WRAP != 0) t.y   = Y_ZERO;
                else                t.blk = 1'b1;
            end
            DIR_LEFT: begin
                if (x != X_ZERO)    t.x   = x - X_ONE;
                else if (WRAP != 0) t.x   = X_LAST;
                else                t.blk = 1'b1;
            end
            DIR_RIGHT: begin
                if (x != X_LAST)    t.x   = x + X_ONE;
                else if (WRAP != 0) t.x   = X_ZERO;
                else                t.blk = 1'b1;
            end
            default: t.blk = 1'b1;
        endcase
        return t;
    endfunction

    state_t           state_r;
    logic [X_W-1:0]   curr_x_r;
    logic [Y_W-1:0]   curr_y_r;
    logic [X_W-1:0]   next_x_r;
    logic [Y_W-1:0]   next_y_r;
    logic [3:0]       heading_r;
    logic [3:0]       pending_r;
    logic [CNT_W-1:0] pill_count_r;
    logic             power_eat_r;
    logic             move_req_r;
    logic             map_rd_en_r;
    logic [X_W-1:0]   map_rd_x_r;
    logic [Y_W-1:0]   map_rd_y_r;
    logic             tgt_blk_r;
    logic [1:0]       wait_cnt_r;
    logic [1:0]       tile_r;

    logic             dir_valid_s;
    tgt_t             p_tgt_s;
    tgt_t             h_tgt_s;

    // Candidate targets for the pending turn and the current heading.
    always_comb begin
        dir_valid_s = $onehot(bus.dir_in);
        p_tgt_s     = calc_tgt(curr_x_r, curr_y_r, pending_r);
        h_tgt_s     = calc_tgt(curr_x_r, curr_y_r, heading_r);
    end

    // Main controller: pending capture, probe sequencing, move handshake, pill count.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            curr_x_r     <= X_START;
            curr_y_r     <= Y_START;
            next_x_r     <= X_START;
            next_y_r     <= Y_START;
            heading_r    <= DIR_NONE;
            pending_r    <= DIR_NONE;
            pill_count_r <= {CNT_W{1'b0}};
            power_eat_r  <= 1'b0;
            move_req_r   <= 1'b0;
            map_rd_en_r  <= 1'b0;
            map_rd_x_r   <= X_START;
            map_rd_y_r   <= Y_START;
            tgt_blk_r    <= 1'b0;
            wait_cnt_r   <= 2'd0;
            tile_r       <= 2'd0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            map_rd_en_r <= 1'b0;
            power_eat_r <= 1'b0;
            if (dir_valid_s) begin
                pending_r <= bus.dir_in;
            end else begin
                pending_r <= pending_r;
            end

            case (state_r)
                S_IDLE: begin
                    if (bus.step) begin
                        if ((pending_r != DIR_NONE) && (pending_r != heading_r)) begin
                            state_r     <= S_TRY_P;
                            map_rd_en_r <= ~p_tgt_s.blk;
                            map_rd_x_r  <= p_tgt_s.x;
                            map_rd_y_r  <= p_tgt_s.y;
                            tgt_blk_r   <= p_tgt_s.blk;
                        end else if (heading_r != DIR_NONE) begin
                            state_r     <= S_TRY_H;
                            map_rd_en_r <= ~h_tgt_s.blk;
                            map_rd_x_r  <= h_tgt_s.x;
                            map_rd_y_r  <= h_tgt_s.y;
                            tgt_blk_r   <= h_tgt_s.blk;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end

                // An edge-blocked pending turn never reads; it falls back at once.
                S_TRY_P: begin
                    wait_cnt_r <= 2'd0;
                    if (!tgt_blk_r) begin
                        state_r <= S_WAIT_P;
                    end else if (heading_r != DIR_NONE) begin
                        state_r     <= S_TRY_H;
                        map_rd_en_r <= ~h_tgt_s.blk;
                        map_rd_x_r  <= h_tgt_s.x;
                        map_rd_y_r  <= h_tgt_s.y;
                        tgt_blk_r   <= h_tgt_s.blk;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end

                S_WAIT_P: begin
                    if (wait_cnt_r == LAT_LAST) begin
                        if (bus.map_rd_data != TILE_WALL) begin
                            // Turn accepted; a direction arriving now becomes the new pending.
                            heading_r  <= pending_r;
                            pending_r  <= dir_valid_s ? bus.dir_in : DIR_NONE;
                            tile_r     <= bus.map_rd_data;
                            next_x_r   <= map_rd_x_r;
                            next_y_r   <= map_rd_y_r;
                            move_req_r <= 1'b1;
                            state_r    <= S_MOVE;
                        end else if (heading_r != DIR_NONE) begin
                            state_r     <= S_TRY_H;
                            map_rd_en_r <= ~h_tgt_s.blk;
                            map_rd_x_r  <= h_tgt_s.x;
                            map_rd_y_r  <= h_tgt_s.y;
                            tgt_blk_r   <= h_tgt_s.blk;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 2'd1;
                    end
                end

                S_TRY_H: begin
                    wait_cnt_r <= 2'd0;
                    if (!tgt_blk_r) begin
                        state_r <= S_WAIT_H;
                    end else begin
                        heading_r <= DIR_NONE;
                        state_r   <= S_IDLE;
                    end
                end

                S_WAIT_H: begin
                    if (wait_cnt_r == LAT_LAST) begin
                        if (bus.map_rd_data != TILE_WALL) begin
                            tile_r     <= bus.map_rd_data;
                            next_x_r   <= map_rd_x_r;
                            next_y_r   <= map_rd_y_r;
                            move_req_r <= 1'b1;
                            state_r    <= S_MOVE;
                        end else begin
                            heading_r <= DIR_NONE;
                            state_r   <= S_IDLE;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 2'd1;
                    end
                end

                // next_x/y stay put after the ack, so next equals curr while idle.
                S_MOVE: begin
                    if (bus.move_ack) begin
                        curr_x_r   <= next_x_r;
                        curr_y_r   <= next_y_r;
                        move_req_r <= 1'b0;
                        state_r    <= S_IDLE;
                        if (tile_r[1] && (pill_count_r != CNT_MAX)) begin
                            pill_count_r <= pill_count_r + CNT_ONE;
                        end else begin
                            pill_count_r <= pill_count_r;
                        end
                        power_eat_r <= (tile_r == TILE_PWR);
                    end else begin
                        state_r <= S_MOVE;
                    end
                end

                default: begin
                    state_r    <= S_IDLE;
                    move_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.map_rd_en  = map_rd_en_r;
    assign bus.map_rd_x   = map_rd_x_r;
    assign bus.map_rd_y   = map_rd_y_r;
    assign bus.move_req   = move_req_r;
    assign bus.curr_x     = curr_x_r;
    assign bus.curr_y     = curr_y_r;
    assign bus.next_x     = next_x_r;
    assign bus.next_y     = next_y_r;
    assign bus.heading    = heading_r;
    assign bus.pill_count = pill_count_r;
    assign bus.power_eat  = power_eat_r;
    assign bus.busy       = (state_r != S_IDLE);

endmodule

// File: doc/sprite_loc_ctrl.md
# sprite_loc_ctrl

Parametrised grid-position controller for any maze sprite (Pac-Man or ghost), the next generation of the Pac-Man location controller. It holds the sprite's current tile, buffers the most recent joystick/AI direction as a pending turn, and on each movement tick checks the map RAM for walls. It tries the pending turn first, then the current heading, wrapping through tunnel edges when enabled. The resulting move is handed to the RAM-write module with a req/ack handshake, and pills eaten are counted.

## Interface
- X_W, 6: x coordinate width
- Y_W, 5: y coordinate width
- MAP_W, 40: tiles per row; legal x is 0..MAP_W-1
- MAP_H, 30: tile rows; legal y is 0..MAP_H-1
- START_X, 20: reset x
- START_Y, 20: reset y
- RD_LAT, 1: map read latency in cycles (1..3)
- WRAP, 1: 1 = edge tunnels wrap, 0 = edges act as walls
- CNT_W, 16: pill counter width

- CLOCK_50  in  1  system clock, single domain
- reset_n  in  1  asynchronous, active-low reset
- dir_in  in  4  {up,down,left,right}; only one-hot values are accepted
- step  in  1  movement tick, one-cycle pulse
- map_rd_en  out  1  map read strobe, one cycle wide
- map_rd_x / map_rd_y  out  X_W / Y_W  read address
- map_rd_data  in  2  tile code: 0 empty, 1 wall, 2 pill, 3 power pill
- move_req  out  1  move pending to the RAM writer
- move_ack  in  1  RAM writer done; old tile cleared and new tile written
- curr_x / curr_y  out  X_W / Y_W  current tile
- next_x / next_y  out  X_W / Y_W  target tile; valid while move_req is high
- heading  out  4  current one-hot direction; 0 = stopped
- pill_count  out  CNT_W  pills plus power pills eaten
- power_eat  out  1  one-cycle pulse when a power pill is eaten
- busy  out  1  high whenever the state is not IDLE

## Operation
- Pending register: any one-hot dir_in loads `pending`, in any state. Zero or multi-hot values leave it unchanged.
- Target computation, per direction d: up is y-1, down is y+1, left is x-1, right is x+1. At an edge, with WRAP=1 the target wraps to the opposite edge (MAP_W-1 / MAP_H-1, or 0). With WRAP=0 the move is blocked without issuing a read.
- Arithmetic is modulo the map dimension, never modulo 2^W. MAP_W and MAP_H need not be powers of two.
- States:
  - IDLE: on `step`, go to TRY_P if pending≠0 and pending≠heading. Otherwise go to TRY_H if heading≠0. Otherwise stay in IDLE.
  - TRY_P: issue the read for the pending target, then go to WAIT_P.
  - WAIT_P: wait RD_LAT cycles, then sample. If the tile is not a wall: heading←pending, pending←0, go to MOVE. If it is a wall or edge-blocked: go to TRY_H if heading≠0, else IDLE. Pending is kept so the turn is retried on the next step.
  - TRY_H / WAIT_H: same read-and-wait sequence for the heading target. Not a wall: go to MOVE. Wall: heading←0, go to IDLE (sprite stops).
  - MOVE: move_req=1 with next_x/y held stable. On move_ack: curr←next, go to IDLE. If the sampled tile was 2 or 3, pill_count increments (saturating at all-ones). Tile 3 also pulses power_eat.
- `step` outside IDLE is dropped; there is no queuing.
- move_ack outside MOVE is ignored.
- next_x/y equal curr_x/y whenever move_req=0.

## Timing
- Reset (async assert, sync release):
  - state IDLE; curr and next = START_X/START_Y
  - heading, pending, pill_count = 0
  - move_req, map_rd_en, power_eat, busy = 0
- Reset mid-operation aborts any read or move immediately. curr is not updated and move_req drops asynchronously.
- map_rd_en is high exactly one cycle per attempt. map_rd_data is sampled on the RD_LAT-th rising edge after that cycle.
- Best-case step-to-move_req latency is 2+RD_LAT cycles (IDLE→TRY→WAIT→MOVE). A pending attempt that hits a wall and falls back adds 1+RD_LAT cycles.
- move_ack may arrive in the first cycle move_req is high. curr updates on that edge and move_req is low on the next cycle.
- A dir_in captured in the same cycle that WAIT_P consumes pending is taken as the new pending; the consumed value is cleared first.
- busy is combinational from state.

## Test plan
- Reset release with defaults: curr=(20,20), heading=0, pill_count=0. Pulse step with dir_in=0 → no map_rd_en, busy stays 0.
- dir_in=right, step, empty map, ack after 3 cycles → map_rd addr (21,20), move_req for 3 cycles, curr=(21,20), heading=0001. A second step with no input → moves to (22,20).
- Heading right, pending=up, wall at (22,19), open (23,20)... step from (22,20) → two reads, (22,19) then (23,20). Moves right, pending stays up.
- MAP_W=40, WRAP=1, curr=(39,5), right → reads (0,5) and moves there. Same case with WRAP=0 → no read, heading becomes 0, no move_req.
- Pill at target → pill_count 0→1. Power pill → count 1→2 plus a one-cycle power_eat. Force pill_count to all-ones and eat → count holds.
- Assert reset_n low while move_req is high → move_req drops immediately, curr returns to (20,20). step during MOVE → ignored, one move only.
